// File: rtl/dmem_responder_if.sv
// Load/store port between the CPU (master) and the data-memory responder (slave).
// Signal names keep the responder's point of view for direction suffixes.
interface dmem_responder_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic [3:0]  req_be_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;

  modport master (
    output req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_be_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
  );

  modport slave (
    input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_be_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
  );
endinterface

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory target: one request at a time, programmable access latency.
// Define DMEM_WRITE_RESP_EN to make stores return a response like loads.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 2
) (
  input logic             clk_i,
  input logic             rst_i,
  dmem_responder_if.slave bus
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;
  logic        req_ready_q;
  logic        rsp_valid_q;
  logic        rsp_err_q;
  logic [31:0] rsp_rdata_q;

  logic [31:0] mem_q [DEPTH_WORDS];

  logic          accept_c;
  logic          access_c;
  logic          commit_c;
  logic [29:0]   word_c;
  logic [AW-1:0] idx_c;
  logic          rsp_err_d;
  logic [31:0]   rsp_rdata_d;

  // Access decode for the edge that leaves WAIT; a zero count still spends one cycle in WAIT.
  always_comb begin
    accept_c    = 1'b0;
    access_c    = 1'b0;
    commit_c    = 1'b0;
    word_c      = addr_q[31:2];
    idx_c       = word_c[AW-1:0];
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;
    accept_c    = (state_q == S_IDLE) && req_ready_q && bus.req_valid_i;
    access_c    = (state_q == S_WAIT) && (cnt_q == 4'd0);
    rsp_err_d   = (addr_q[1:0] != 2'b00) || (word_c >= 30'(DEPTH_WORDS));
    commit_c    = access_c && we_q && !rsp_err_d;
    if (!rsp_err_d && !we_q) begin
      rsp_rdata_d = mem_q[idx_c];
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          req_ready_q <= 1'b1;
          if (accept_c) begin
            we_q        <= bus.req_we_i;
            addr_q      <= bus.req_addr_i;
            wdata_q     <= bus.req_wdata_i;
            be_q        <= bus.req_be_i;
            cnt_q       <= 4'(LATENCY);
            req_ready_q <= 1'b0;
            state_q     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (!access_c) begin
            cnt_q <= 4'(cnt_q - 4'd1);
          end else begin
`ifdef DMEM_WRITE_RESP_EN
            state_q     <= S_RESP;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
`else
            // Stores finish silently here; only loads produce a response.
            if (we_q) begin
              state_q     <= S_IDLE;
              req_ready_q <= 1'b1;
            end else begin
              state_q     <= S_RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= rsp_err_d;
              rsp_rdata_q <= rsp_rdata_d;
            end
`endif
          end
        end
        S_RESP: begin
          if (bus.rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            req_ready_q <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk_i) begin
    if (commit_c) begin
      for (int i = 0; i < 4; i++) begin
        if (be_q[i]) begin
          mem_q[idx_c][8*i +: 8] <= wdata_q[8*i +: 8];
        end
      end
    end
  end

  assign bus.req_ready_o = req_ready_q;
  assign bus.rsp_valid_o = rsp_valid_q;
  assign bus.rsp_err_o   = rsp_err_q;
  assign bus.rsp_rdata_o = rsp_rdata_q;

endmodule
